mem_stage_ctrl: RTL

- Memory-stage controller of the 5-stage pipeline.
- Consumes the M-pipe payload (rs2, execution_result, mem/wb control) and runs the data-cache request/response handshake for loads and stores.
- Produces the registered W-pipe payload (execution_result, mem_data, is_load, wb control) and back-pressures upstream stages with a stall while a memory access is in flight.

---
 rtl/mem_stage_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_ctrl
// Brief    : M-stage controller: data-cache handshake, store lane formatting,
//            load extraction and the registered W-pipe payload.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
    parameter int REG_WIDTH = 32,
    parameter int RD_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_valid,
    input  logic                 m_is_load,
    input  logic                 m_is_store,
    input  logic [1:0]           m_size,
    input  logic                 m_unsigned,
    input  logic [REG_WIDTH-1:0] m_addr,
    input  logic [REG_WIDTH-1:0] m_rs2,
    input  logic [RD_WIDTH-1:0]  m_rd,
    input  logic                 m_reg_write,
    output logic                 stall_o,
    output logic                 dc_req_valid,
    input  logic                 dc_req_ready,
    output logic                 dc_req_we,
    output logic [REG_WIDTH-1:0] dc_req_addr,
    output logic [REG_WIDTH-1:0] dc_req_wdata,
    output logic [3:0]           dc_req_wstrb,
    input  logic                 dc_resp_valid,
    input  logic [REG_WIDTH-1:0] dc_resp_rdata,
    output logic                 w_valid,
    output logic [REG_WIDTH-1:0] w_execution_result,
    output logic [REG_WIDTH-1:0] w_mem_data,
    output logic                 w_is_load,
    output logic [RD_WIDTH-1:0]  w_rd,
    output logic                 w_reg_write,
    output logic                 w_misaligned
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic                 w_mem_op;
    logic                 w_addr_misaligned;
    logic                 w_mem_misaligned;
    logic                 w_access;
    logic                 w_retire;
    logic [7:0]           w_load_byte;
    logic [15:0]          w_load_half;
    logic [REG_WIDTH-1:0] w_load_data;

    assign w_mem_op = m_valid & (m_is_load | m_is_store);

    always_comb begin
        w_addr_misaligned = 1'b0;
        case (m_size)
            2'b00:   w_addr_misaligned = 1'b0;
            2'b01:   w_addr_misaligned = m_addr[0];
            default: w_addr_misaligned = |m_addr[1:0];
        endcase
    end

    assign w_mem_misaligned = w_mem_op & w_addr_misaligned;
    assign w_access         = w_mem_op & ~w_addr_misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A load+store encoding follows the load path; the response is only
    // looked at once the request has been accepted (RESP).
    always_comb begin
        w_next_state = r_state;
        dc_req_valid = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            ST_IDLE, ST_REQ: begin
                if (w_access) begin
                    dc_req_valid = 1'b1;
                    if (dc_req_ready) begin
                        if (m_is_load) begin
                            w_next_state = ST_RESP;
                        end else begin
                            w_retire     = 1'b1;
                            w_next_state = ST_IDLE;
                        end
                    end else begin
                        w_next_state = ST_REQ;
                    end
                end else begin
                    w_retire     = m_valid;
                    w_next_state = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (dc_resp_valid) begin
                    w_retire     = m_valid;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign stall_o     = m_valid & ~w_retire;
    assign dc_req_we   = m_is_store & ~m_is_load;
    assign dc_req_addr = {m_addr[REG_WIDTH-1:2], 2'b00};

    always_comb begin
        dc_req_wdata = m_rs2;
        dc_req_wstrb = 4'b1111;
        case (m_size)
            2'b00: begin
                dc_req_wdata = {4{m_rs2[7:0]}};
                dc_req_wstrb = 4'b0001 << m_addr[1:0];
            end
            2'b01: begin
                dc_req_wdata = {2{m_rs2[15:0]}};
                dc_req_wstrb = m_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                dc_req_wdata = m_rs2;
                dc_req_wstrb = 4'b1111;
            end
        endcase
    end

    assign w_load_byte = dc_resp_rdata[{m_addr[1:0], 3'b000} +: 8];
    assign w_load_half = dc_resp_rdata[{m_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = dc_resp_rdata;
        case (m_size)
            2'b00:   w_load_data = {{(REG_WIDTH-8){w_load_byte[7] & ~m_unsigned}}, w_load_byte};
            2'b01:   w_load_data = {{(REG_WIDTH-16){w_load_half[15] & ~m_unsigned}}, w_load_half};
            default: w_load_data = dc_resp_rdata;
        endcase
    end

    // Bubbles only clear the qualifiers; the data fields keep their last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid            <= 1'b0;
            w_execution_result <= '0;
            w_mem_data         <= '0;
            w_is_load          <= 1'b0;
            w_rd               <= '0;
            w_reg_write        <= 1'b0;
            w_misaligned       <= 1'b0;
        end else if (w_retire) begin
            w_valid            <= 1'b1;
            w_execution_result <= m_addr;
            w_mem_data         <= (m_is_load & ~w_mem_misaligned) ? w_load_data : '0;
            w_is_load          <= m_is_load;
            w_rd               <= m_rd;
            w_reg_write        <= m_reg_write & ~w_mem_misaligned;
            w_misaligned       <= w_mem_misaligned;
        end else begin
            w_valid            <= 1'b0;
            w_reg_write        <= 1'b0;
            w_misaligned       <= 1'b0;
        end
    end

endmodule
`default_nettype wire
